multdiv_seq: RTL
================

# multdiv_seq

Sequencer that sits between the processor's decode/execute stage and the shared `multdiv` unit. It accepts one multiply or divide request at a time and holds the operands stable for the unit. It issues the single-cycle `ctrl_MULT`/`ctrl_DIV` start pulse and waits for `data_resultRDY`. It then presents the captured result, exception flag and destination tag to writeback over a valid/ready handshake, stalling the pipeline while busy.

## Interface
- `DATA_W`, 32, operand/result width
- `TAG_W`, 5, destination-register tag width
- `TIMEOUT_CYC`, 40, watchdog limit in WAIT cycles (used only with `MULTDIV_TIMEOUT_EN`)

- `clock`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  abort in-flight operation (synchronous)
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept request
- `req_op`  in  1  0 = multiply, 1 = divide
- `req_a`, `req_b`  in  DATA_W  operands
- `req_tag`  in  TAG_W  destination register
- `md_a`, `md_b`  out  DATA_W  registered operands to multdiv
- `md_ctrl_mult`, `md_ctrl_div`  out  1  one-cycle start pulses
- `md_result`  in  DATA_W  multdiv result
- `md_exception`  in  1  multdiv overflow / divide-by-zero
- `md_rdy`  in  1  multdiv result ready
- `wb_valid`  out  1  result available
- `wb_ready`  in  1  writeback accepts result
- `wb_result`  out  DATA_W, `wb_exception` out 1, `wb_tag` out TAG_W  captured outputs
- `stall`  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, START, WAIT, DONE. 2-bit encoded register.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_a`/`req_b`/`req_op`/`req_tag`, go to START.
- START: drive exactly one of `md_ctrl_mult`/`md_ctrl_div` high for this cycle only, then go to WAIT.
- WAIT: in the first WAIT cycle, ignore `md_rdy` (a stale ready from the previous op). From the second WAIT cycle on, `md_rdy`=1 captures `md_result` and `md_exception` into the wb registers, then goes to DONE.
- DONE: `wb_valid`=1, wb outputs held stable.
  - `wb_ready`=1 with no `req_valid`: go to IDLE.
  - `wb_ready`=1 and `req_valid`=1 (`req_ready`=1 in this case): latch the new request and go directly to START, with no IDLE bubble.
- `req_ready` = (state==IDLE) | (state==DONE & `wb_ready`).
- `md_a`/`md_b` change only on request acceptance; they are held through WAIT and DONE.
- `flush`: from any state, go to IDLE on the next edge and drop `wb_valid`. No start pulse is issued that cycle. `flush` has priority over every other input. An abandoned multdiv op is restarted by the next START pulse.
- Result and operands pass through unmodified; no width change or sign handling in this block.

## Timing
- Reset (async assert, sync deassert by the surrounding design):
  - state=IDLE
  - all outputs 0 except `req_ready`=1
  - `md_a`, `md_b`, wb registers = 0
- All outputs are registered or decoded from state only. `req_ready` is the sole exception: it is combinational on `wb_ready`.
- Request accepted at edge 0. Start pulse high in cycle 1. WAIT from cycle 2.
- `md_rdy` sampled high at edge k gives `wb_valid` high from cycle k+1. Overhead is 2 cycles beyond multdiv latency.
- If `md_rdy` is high in the first WAIT cycle, it is ignored. Capture occurs on the next cycle it is high.
- `reset_n` low mid-WAIT: state returns to IDLE immediately. The start pulse is never re-issued without a new request.
- `wb_ready` held low: DONE persists indefinitely. wb outputs and `stall` stay constant.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - A cycle counter of width ⌈log2(TIMEOUT_CYC+1)⌉ clears on entry to WAIT and increments each WAIT cycle.
  - On reaching `TIMEOUT_CYC` without a qualified `md_rdy`, go to DONE with `wb_exception`=1 and `wb_result`=0.
  - `md_rdy` in the same cycle as timeout wins; the result is captured normally.
- `MULTDIV_TIMEOUT_EN` undefined: no counter. WAIT exits only on `md_rdy` or `flush`.

## Test plan
- MULT, A=-1, B=-1, `wb_ready`=1 → one `md_ctrl_mult` pulse in cycle 1; `wb_result`=1, `wb_exception`=0, `wb_tag`=req_tag, `wb_valid` for 1 cycle.
- DIV, A=7, B=0, model asserts `md_exception` with `md_rdy` → `wb_exception`=1; `md_ctrl_div` pulsed exactly once; `md_ctrl_mult` never high.
- MULT 3×5 with `wb_ready` low 5 cycles, then a second request held valid → `wb_result`=15 stable for 5 cycles, `req_ready`=0. On the `wb_ready` edge the second op goes straight to START.
- `md_rdy` stuck high from the previous op, new DIV 20/4 → first WAIT cycle ignored. Capture occurs only after the model's fresh `md_rdy` (result 5).
- `flush` in the 3rd WAIT cycle, then a new MULT 2×2 → IDLE next cycle, no `wb_valid` for the flushed op; the new op yields 4. Repeat with `reset_n` pulsed low mid-WAIT → outputs at reset values.
- With `MULTDIV_TIMEOUT_EN`, `TIMEOUT_CYC`=8, model never asserts `md_rdy` → `wb_valid`=1 with `wb_exception`=1, `wb_result`=0 after 8 WAIT cycles. Without the macro → `stall` held for 100 cycles.

Source files
------------

// File: rtl/multdiv_seq.sv
// Sequencer between decode/execute and the shared multdiv unit: one op in flight,
// start pulse, result capture, valid/ready writeback. Optional watchdog: MULTDIV_TIMEOUT_EN.
module multdiv_seq #(
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_rdy,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_result,
  output logic              wb_exception,
  output logic [TAG_W-1:0]  wb_tag,
  output logic              stall,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; req_* and wb_* are held stable by their producer until that edge.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               op_r;
  logic               first_wait;
  logic [TAG_W-1:0]   tag_r;
  logic               accept;
  logic               capture;
  logic               timeout;

  assign accept  = req_valid & req_ready & ~flush;
  // md_rdy in the first WAIT cycle belongs to the previous operation.
  assign capture = (state == S_WAIT) & ~first_wait & md_rdy & ~flush;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt holds the number of WAIT cycles already completed.
  assign timeout = (state == S_WAIT) & ~flush & ~capture &
                   (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == S_START) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    wb_valid     = 1'b0;
    stall        = (state != S_IDLE);
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (req_valid) state_nxt = S_START;
        S_START: state_nxt = S_WAIT;
        S_WAIT:  if (capture || timeout) state_nxt = S_DONE;
        S_DONE:  if (wb_ready) state_nxt = req_valid ? S_START : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
    case (state)
      S_IDLE:  req_ready = 1'b1;
      S_START: begin
        md_ctrl_mult = ~op_r;
        md_ctrl_div  = op_r;
      end
      S_DONE: begin
        wb_valid  = 1'b1;
        req_ready = wb_ready;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      first_wait <= 1'b0;
    end else begin
      state      <= state_nxt;
      first_wait <= (state == S_START) & ~flush;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_a         <= '0;
      md_b         <= '0;
      op_r         <= 1'b0;
      tag_r        <= '0;
      wb_result    <= '0;
      wb_exception <= 1'b0;
      wb_tag       <= '0;
    end else begin
      if (accept) begin
        md_a  <= req_a;
        md_b  <= req_b;
        op_r  <= req_op;
        tag_r <= req_tag;
      end
      if (capture) begin
        wb_result    <= md_result;
        wb_exception <= md_exception;
        wb_tag       <= tag_r;
      end else if (timeout) begin
        wb_result    <= '0;
        wb_exception <= 1'b1;
        wb_tag       <= tag_r;
      end
    end
  end

endmodule
